// File: rtl/icache_dm_pkg.sv
// Shared definitions for the instruction cache: FSM states, address-field
// derivation and the word-at-a-time memory-bus handshake (reused by the dcache).
package icache_dm_pkg;

   localparam int XLEN           = 32;
   localparam int DEF_LINE_WORDS = 4;
   localparam int DEF_LINES      = 64;

   function automatic int off_w(input int line_words);
      return $clog2(line_words) + 2;
   endfunction

   function automatic int idx_w(input int lines);
      return $clog2(lines);
   endfunction

   function automatic int tag_w(input int line_words, input int lines);
      return XLEN - off_w(line_words) - idx_w(lines);
   endfunction

   localparam int DEF_OFF_W = off_w(DEF_LINE_WORDS);
   localparam int DEF_IDX_W = idx_w(DEF_LINES);
   localparam int DEF_TAG_W = tag_w(DEF_LINE_WORDS, DEF_LINES);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_FILL = 1'b1
   } state_e;

   // One word per handshake: rd held until ack, ack lasts exactly one cycle.
   typedef struct packed {
      logic            rd;
      logic [XLEN-1:0] addr;
   } mem_req_t;

   typedef struct packed {
      logic            ack;
      logic [XLEN-1:0] data;
   } mem_rsp_t;

endpackage

// File: rtl/icache_ram.sv
// Tag/valid/data store for the direct-mapped icache: asynchronous read,
// one synchronous write port (data word, plus tag/valid on line commit).
module icache_ram
   import icache_dm_pkg::*;
#(
   parameter int LINES      = DEF_LINES,
   parameter int LINE_WORDS = DEF_LINE_WORDS,
   parameter int TAG_W      = DEF_TAG_W
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          clr_all,
   input  logic [$clog2(LINES)-1:0]      rd_idx,
   input  logic [$clog2(LINE_WORDS)-1:0] rd_word,
   output logic                          rd_valid,
   output logic [TAG_W-1:0]              rd_tag,
   output logic [XLEN-1:0]               rd_data,
   input  logic                          wr_en,
   input  logic                          wr_commit,
   input  logic                          wr_set_valid,
   input  logic [$clog2(LINES)-1:0]      wr_idx,
   input  logic [$clog2(LINE_WORDS)-1:0] wr_word,
   input  logic [XLEN-1:0]               wr_data,
   input  logic [TAG_W-1:0]              wr_tag
);

   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_mem  [LINES];
   logic [XLEN-1:0]  data_mem [LINES*LINE_WORDS];

   // Clearing wins over the commit, so a flushed fill never becomes valid.
   always_ff @(posedge i_clk) begin
      if (i_rst || clr_all)
         valid_q <= '0;
      else if (wr_commit && wr_set_valid)
         valid_q[wr_idx] <= 1'b1;
   end

   // NOTE: arrays carry no reset; their contents are meaningless until the
   // line's valid bit is set, and a reset would block LUT-RAM mapping.
   always_ff @(posedge i_clk) begin
      if (wr_en)
         data_mem[{wr_idx, wr_word}] <= wr_data;
      if (wr_en && wr_commit)
         tag_mem[wr_idx] <= wr_tag;
   end

   assign rd_valid = valid_q[rd_idx];
   assign rd_tag   = tag_mem[rd_idx];
   assign rd_data  = data_mem[{rd_idx, rd_word}];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: zero-latency hit path, line fill
// FSM, flush handling. Define ICACHE_STATS_EN to build the hit/miss counters.
module icache_dm
   import icache_dm_pkg::*;
#(
   parameter int LINE_WORDS = DEF_LINE_WORDS,
   parameter int LINES      = DEF_LINES
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_req,
   input  logic [XLEN-1:0] i_addr,
   input  logic            i_flush,
   output logic            o_valid,
   output logic [XLEN-1:0] o_data,
   output logic [XLEN-1:0] o_mem_addr,
   output logic            o_mem_rd,
   input  logic [XLEN-1:0] i_mem_data,
   input  logic            i_mem_ack,
   output logic [XLEN-1:0] o_hit_cnt,
   output logic [XLEN-1:0] o_miss_cnt
);

   localparam int OFF_W  = off_w(LINE_WORDS);
   localparam int IDX_W  = idx_w(LINES);
   localparam int TAG_W  = tag_w(LINE_WORDS, LINES);
   localparam int WORD_W = OFF_W - 2;

   state_e             state_q, state_d;
   logic [TAG_W-1:0]   tag_q;
   logic [IDX_W-1:0]   idx_q;
   logic [WORD_W-1:0]  cnt_q;
   logic               flush_pend_q;

   mem_req_t           mem_req;
   mem_rsp_t           mem_rsp;
   logic [TAG_W-1:0]   a_tag;
   logic [IDX_W-1:0]   a_idx;
   logic [WORD_W-1:0]  a_word;
   logic               rd_valid;
   logic [TAG_W-1:0]   rd_tag;
   logic               hit, fill_ack, commit, flush_now, start_fill, clr_all;
   logic               unused_addr_lsb;

   assign mem_rsp         = '{ack: i_mem_ack, data: i_mem_data};
   assign a_tag           = i_addr[XLEN-1 -: TAG_W];
   assign a_idx           = i_addr[OFF_W +: IDX_W];
   assign a_word          = i_addr[2 +: WORD_W];
   assign unused_addr_lsb = ^i_addr[1:0];

   assign fill_ack  = (state_q == S_FILL) && mem_rsp.ack && !i_rst;
   assign commit    = fill_ack && (&cnt_q);
   assign flush_now = flush_pend_q || i_flush;
   assign hit       = (state_q == S_IDLE) && rd_valid && (rd_tag == a_tag) && !i_flush;

   assign o_valid    = hit && i_req;
   assign o_mem_rd   = mem_req.rd;
   assign o_mem_addr = mem_req.addr;

   icache_ram #(
      .LINES      (LINES),
      .LINE_WORDS (LINE_WORDS),
      .TAG_W      (TAG_W)
   ) u_ram (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .clr_all      (clr_all),
      .rd_idx       (a_idx),
      .rd_word      (a_word),
      .rd_valid     (rd_valid),
      .rd_tag       (rd_tag),
      .rd_data      (o_data),
      .wr_en        (fill_ack),
      .wr_commit    (commit),
      .wr_set_valid (!flush_now),
      .wr_idx       (idx_q),
      .wr_word      (cnt_q),
      .wr_data      (mem_rsp.data),
      .wr_tag       (tag_q)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // NOTE: every combinational output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      start_fill = 1'b0;
      clr_all    = 1'b0;
      mem_req    = '0;
      case (state_q)
         S_IDLE: begin
            if (i_flush)
               clr_all = 1'b1;
            else if (!hit && i_req) begin
               start_fill = 1'b1;
               state_d    = S_FILL;
            end
         end
         S_FILL: begin
            mem_req.rd   = 1'b1;
            mem_req.addr = {tag_q, idx_q, cnt_q, 2'b00};
            if (commit) begin
               clr_all = flush_now;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tag_q        <= '0;
         idx_q        <= '0;
         cnt_q        <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         if (start_fill) begin
            tag_q <= a_tag;
            idx_q <= a_idx;
            cnt_q <= '0;
         end else if (fill_ack) begin
            cnt_q <= cnt_q + WORD_W'(1);
         end
         if (commit)
            flush_pend_q <= 1'b0;
         else if (state_q == S_FILL && i_flush)
            flush_pend_q <= 1'b1;
      end
   end

`ifdef ICACHE_STATS_EN
   logic [XLEN-1:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (o_valid)
            hit_cnt_q <= hit_cnt_q + XLEN'(1);
         if (start_fill)
            miss_cnt_q <= miss_cnt_q + XLEN'(1);
      end
   end

   assign o_hit_cnt  = hit_cnt_q;
   assign o_miss_cnt = miss_cnt_q;
`else
   assign o_hit_cnt  = '0;
   assign o_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: memory responder acking two cycles after each
// request with data 0x1000_0000+addr, a hit-vector table and fill sequences.
module tb_icache_dm;

   logic        i_clk = 1'b0;
   logic        i_rst, i_req, i_flush, i_mem_ack;
   logic [31:0] i_addr, i_mem_data;
   logic        o_valid, o_mem_rd;
   logic [31:0] o_data, o_mem_addr, o_hit_cnt, o_miss_cnt;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] log_q[$];
   bit          mem_en = 1'b0;
   int          wcnt   = 0;

   typedef struct {
      logic [31:0] addr;
      logic        req;
      logic        exp_valid;
      logic [31:0] exp_data;
   } vec_t;
   vec_t vecs[10];

   icache_dm dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_req      (i_req),
      .i_addr     (i_addr),
      .i_flush    (i_flush),
      .o_valid    (o_valid),
      .o_data     (o_data),
      .o_mem_addr (o_mem_addr),
      .o_mem_rd   (o_mem_rd),
      .i_mem_data (i_mem_data),
      .i_mem_ack  (i_mem_ack),
      .o_hit_cnt  (o_hit_cnt),
      .o_miss_cnt (o_miss_cnt)
   );

   always #5 i_clk = ~i_clk;

   // Memory model: acks on the third cycle a request is seen.
   initial begin
      forever begin
         @(negedge i_clk);
         if (mem_en) begin
            i_mem_ack = 1'b0;
            if (o_mem_rd) begin
               if (wcnt == 2) begin
                  i_mem_ack  = 1'b1;
                  i_mem_data = 32'h1000_0000 + o_mem_addr;
                  log_q.push_back(o_mem_addr);
                  wcnt = 0;
               end else begin
                  wcnt++;
               end
            end else begin
               wcnt = 0;
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, act, exp);
      end
   endtask

   // act: 0 none, 1 one-cycle flush pulse after first ack, 2 switch i_addr after first ack
   task automatic run_fill(input logic [31:0] base, input int act, input logic [31:0] new_addr);
      bit seen  = 1'b0;
      bit done  = 1'b0;
      bit acted = 1'b0;
      int cyc   = 0;
      log_q.delete();
      while (!done && cyc < 200) begin
         @(negedge i_clk);
         #1;
         cyc++;
         if (i_flush) i_flush = 1'b0;
         if (o_mem_rd) seen = 1'b1;
         else if (seen) done = 1'b1;
         if (!done && !acted && act != 0 && log_q.size() == 1) begin
            acted = 1'b1;
            if (act == 1) i_flush = 1'b1;
            else i_addr = new_addr;
         end
      end
      check($sformatf("fill_done_%h", base), 32'(done), 32'd1);
      check($sformatf("fill_words_%h", base), 32'(log_q.size()), 32'd4);
      for (int k = 0; k < log_q.size() && k < 4; k++)
         check($sformatf("fill_addr_%h_w%0d", base, k), log_q[k], base + 32'(4 * k));
   endtask

   initial begin
      i_rst = 1'b1; i_req = 1'b0; i_addr = 32'h0; i_flush = 1'b0;
      i_mem_ack = 1'b0; i_mem_data = 32'h0;
      repeat (2) @(negedge i_clk);

      // Reset state
      i_rst = 1'b0; i_req = 1'b1; #1;
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_mem_rd", 32'(o_mem_rd), 32'd0);
      check("rst_mem_addr", o_mem_addr, 32'h0);
      check("rst_hit_cnt", o_hit_cnt, 32'h0);
      check("rst_miss_cnt", o_miss_cnt, 32'h0);

      // Cold miss, then three hit cycles
      mem_en = 1'b1;
      run_fill(32'h0, 0, 32'h0);
      check("cold_valid", 32'(o_valid), 32'd1);
      check("cold_data", o_data, 32'h1000_0000);
      i_addr = 32'h8; #1;
      check("hit8_valid", 32'(o_valid), 32'd1);
      check("hit8_data", o_data, 32'h1000_0008);
      check("hit8_mem_rd", 32'(o_mem_rd), 32'd0);
      @(negedge i_clk);
      i_addr = 32'h4; #1;
      check("hit4_data", o_data, 32'h1000_0004);
      @(negedge i_clk);
      i_addr = 32'hC; #1;
      check("hitc_data", o_data, 32'h1000_000C);
      @(negedge i_clk);
      i_req = 1'b0; #1;
`ifdef ICACHE_STATS_EN
      check("stats_hit", o_hit_cnt, 32'd3);
      check("stats_miss", o_miss_cnt, 32'd1);
      force dut.hit_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.hit_cnt_q;
      i_req = 1'b1; i_addr = 32'h0;
      @(negedge i_clk);
      i_req = 1'b0; #1;
      check("stats_hit_wrap", o_hit_cnt, 32'h0);
      check("stats_miss_hold", o_miss_cnt, 32'd1);
`else
      check("nostats_hit", o_hit_cnt, 32'h0);
      check("nostats_miss", o_miss_cnt, 32'h0);
`endif

      // Second line, then the hit table
      i_req = 1'b1; i_addr = 32'h20;
      run_fill(32'h20, 0, 32'h0);
      vecs[0] = '{32'h000, 1'b1, 1'b1, 32'h1000_0000};
      vecs[1] = '{32'h004, 1'b1, 1'b1, 32'h1000_0004};
      vecs[2] = '{32'h00B, 1'b1, 1'b1, 32'h1000_0008};
      vecs[3] = '{32'h00C, 1'b1, 1'b1, 32'h1000_000C};
      vecs[4] = '{32'h020, 1'b1, 1'b1, 32'h1000_0020};
      vecs[5] = '{32'h02E, 1'b1, 1'b1, 32'h1000_002C};
      vecs[6] = '{32'h004, 1'b0, 1'b0, 32'h0};
      vecs[7] = '{32'h400, 1'b0, 1'b0, 32'h0};
      vecs[8] = '{32'h010, 1'b0, 1'b0, 32'h0};
      vecs[9] = '{32'h024, 1'b1, 1'b1, 32'h1000_0024};
      for (int i = 0; i < 10; i++) begin
         i_addr = vecs[i].addr; i_req = vecs[i].req; #1;
         check($sformatf("vec%0d_valid", i), 32'(o_valid), 32'(vecs[i].exp_valid));
         if (vecs[i].exp_valid)
            check($sformatf("vec%0d_data", i), o_data, vecs[i].exp_data);
         check($sformatf("vec%0d_mem_rd", i), 32'(o_mem_rd), 32'd0);
         @(negedge i_clk);
      end

      // Conflict eviction on index 0
      i_req = 1'b1; i_addr = 32'h400; #1;
      check("evict_miss", 32'(o_valid), 32'd0);
      run_fill(32'h400, 0, 32'h0);
      check("evict_data", o_data, 32'h1000_0400);
      i_addr = 32'h0; #1;
      check("evict_refetch_miss", 32'(o_valid), 32'd0);
      run_fill(32'h0, 0, 32'h0);
      check("evict_refetch_valid", 32'(o_valid), 32'd1);

      // Flush in IDLE
      i_addr = 32'h20; #1;
      check("flush_pre_hit", 32'(o_valid), 32'd1);
      i_flush = 1'b1; #1;
      check("flush_cycle_valid", 32'(o_valid), 32'd0);
      @(negedge i_clk);
      i_flush = 1'b0; #1;
      check("flush_after_miss", 32'(o_valid), 32'd0);
      run_fill(32'h20, 0, 32'h0);
      check("flush_refill_data", o_data, 32'h1000_0020);

      // Flush during fill: line not validated, everything else cleared
      i_addr = 32'h40;
      run_fill(32'h40, 1, 32'h0);
      check("flush_fill_not_valid", 32'(o_valid), 32'd0);
      run_fill(32'h40, 0, 32'h0);
      check("flush_fill_refill_data", o_data, 32'h1000_0040);
      i_addr = 32'h20; #1;
      check("flush_fill_cleared_other", 32'(o_valid), 32'd0);
      i_req = 1'b0;
      @(negedge i_clk);

      // Reset after two of four acks
      i_req = 1'b1; i_addr = 32'h80;
      log_q.delete();
      for (int c = 0; c < 100 && log_q.size() < 2; c++) begin
         @(negedge i_clk);
         #1;
      end
      check("rst_fill_two_acks", 32'(log_q.size()), 32'd2);
      @(negedge i_clk);
      mem_en = 1'b0; i_mem_ack = 1'b0; i_rst = 1'b1;
      @(negedge i_clk);
      #1;
      check("rst_fill_mem_rd", 32'(o_mem_rd), 32'd0);
      check("rst_fill_valid", 32'(o_valid), 32'd0);
      check("rst_fill_mem_addr", o_mem_addr, 32'h0);
      i_rst = 1'b0; i_req = 1'b0; i_mem_ack = 1'b1; i_mem_data = 32'hDEAD_BEEF;
      @(negedge i_clk);
      i_mem_ack = 1'b0; #1;
      check("stray_ack_mem_rd", 32'(o_mem_rd), 32'd0);
      i_req = 1'b1; #1;
      check("rst_partial_miss", 32'(o_valid), 32'd0);
      mem_en = 1'b1;
      run_fill(32'h80, 0, 32'h0);
      check("rst_refill_data", o_data, 32'h1000_0080);
      i_addr = 32'h84; #1;
      check("rst_refill_w1", o_data, 32'h1000_0084);

      // Address change mid-fill
      i_addr = 32'h100;
      run_fill(32'h100, 2, 32'h300);
      check("switch_new_miss", 32'(o_valid), 32'd0);
      run_fill(32'h300, 0, 32'h0);
      check("switch_300_data", o_data, 32'h1000_0300);
      i_addr = 32'h100; #1;
      check("switch_100_valid", 32'(o_valid), 32'd1);
      check("switch_100_data", o_data, 32'h1000_0100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the core's fetch port and the external memory bus.
- Core side: combinational hit path. Presents an address, gets o_valid/o_data in the same cycle on a hit. o_valid maps directly onto the core's instruction-valid input.
- Miss side: a fill FSM fetches a whole line, one word per memory handshake, then returns to hit service.

Parameters:
- LINE_WORDS, 4, 32-bit words per line; power of two, >=2.
- LINES, 64, number of lines; power of two, >=2.
- Derived: OFF_W = log2(LINE_WORDS)+2, IDX_W = log2(LINES), TAG_W = 32-OFF_W-IDX_W.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_req  in  1  core fetch request (the core ties this to 1)
- i_addr  in  32  fetch byte address; bits [1:0] ignored
- i_flush  in  1  invalidate all lines (fence.i)
- o_valid  out  1  o_data is valid for the current i_addr
- o_data  out  32  instruction word
- o_mem_addr  out  32  word-aligned fill address
- o_mem_rd  out  1  fill read request
- i_mem_data  in  32  fill data, valid when i_mem_ack is high
- i_mem_ack  in  1  one-cycle acknowledge, one word per ack
- o_hit_cnt  out  32  hit counter (optional feature)
- o_miss_cnt  out  32  miss counter (optional feature)

Behaviour:
- Reset: i_rst is synchronous, active-high; clock is i_clk. Reset clears all valid bits, state -> IDLE, word counter = 0. Outputs after reset: o_valid=0, o_mem_rd=0, o_mem_addr=0, counters=0. o_data is don't-care while o_valid=0.
- Storage: tag and data arrays need no reset. The data array is read asynchronously (LUT RAM).
- Hit: in IDLE, when valid[idx] is set and tag[idx] equals i_addr tag, and no flush or fill commit occurs this cycle:
  - o_valid=1;
  - o_data = data[idx][i_addr word offset], combinational, zero-cycle latency.
- o_valid is gated by i_req.
- States:
  - IDLE: hit -> stay. Miss with i_req=1 -> latch {tag, idx}, word counter = 0, go to FILL. Miss with i_req=0 -> stay.
  - FILL: o_mem_rd=1, o_mem_addr = {latched tag, latched idx, counter, 2'b00}. On i_mem_ack: write i_mem_data into the data word, counter+1. On the ack of word LINE_WORDS-1: write the tag, set valid (unless a flush is pending), go to IDLE. The request hits the following cycle.
- o_valid=0 throughout FILL.
- o_mem_rd drops the cycle after the last ack. Words are fetched in ascending order; no critical-word-first.
- i_addr changing during FILL: ignored. The latched line completes, then IDLE re-evaluates the new address, which may start another miss.
- Flush:
  - i_flush in IDLE clears all valid bits at the next edge, and o_valid=0 that cycle.
  - i_flush in FILL sets flush_pending. At fill commit, all valids are cleared and the filled line is not validated. flush_pending is then cleared.
- Reset mid-fill: fill aborts immediately, o_mem_rd=0 next cycle, partial line discarded. A stray later i_mem_ack in IDLE is ignored.
- i_mem_ack outside FILL: ignored.
- Simultaneous i_rst and i_flush: reset wins; the result is the same.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - o_hit_cnt increments each cycle o_valid=1.
  - o_miss_cnt increments on each IDLE->FILL transition.
  - Both are 32-bit, wrap modulo 2^32 (0xFFFFFFFF+1 -> 0), cleared by i_rst, not cleared by i_flush.
- Undefined: both ports are driven constant 0; no counter flops are inferred.

Decomposition:
- Shared package/header holds:
  - FSM state encodings (S_IDLE=1'b0, S_FILL=1'b1);
  - address-field helper constants (OFF_W, IDX_W, TAG_W derivation);
  - the memory-bus word-handshake definition shared with a future dcache.
- One natural sub-module: icache_ram, a parameterised tag+valid+data array with async read and a single sync write port.
- FSM, flush logic and counters stay in icache_dm.

Test Plan:
- Cold miss: reset, i_addr=0x0000_0000, i_req=1, memory acks each request after 2 cycles with data 0x1000_0000+addr.
  - Expect o_mem_addr 0x0, 0x4, 0x8, 0xC in order.
  - o_valid=1 with o_data=0x1000_0000 the cycle after the 4th ack.
  - i_addr=0x8 then hits the same cycle with 0x1000_0008, and no o_mem_rd.
- Conflict eviction: fill 0x000, then fetch 0x400 (same idx 0).
  - Expect a miss with fill 0x400..0x40C.
  - A following fetch of 0x000 misses again.
- Flush: line 0x20 valid, pulse i_flush one cycle.
  - o_valid=0 that cycle; the next fetch of 0x20 misses.
  - Flush asserted during a fill: after the fill, the same address misses again.
- Reset mid-fill: i_rst after 2 of 4 acks.
  - o_mem_rd=0 next cycle, o_valid=0.
  - A late i_mem_ack is ignored; refetch performs a full 4-word fill starting at word 0.
- Address change mid-fill: miss on 0x100, switch i_addr to 0x300 after the first ack.
  - Fill 0x100..0x10C completes, then fill 0x300..0x30C; 0x100 subsequently hits.
- ICACHE_STATS_EN: cold miss + 3 hit cycles -> o_miss_cnt=1, o_hit_cnt=3. Force the hit counter to 0xFFFFFFFF and one hit -> 0.
